modulation_buffer_dual: RTL

- Double-buffered duty/phase holding register for the modulation path.
- A serial write port loads a shadow bank of DEPTH entries inside a START/DONE window.
- DONE commits the shadow bank atomically to parallel DUTY_OUT/PHASE_OUT arrays, so downstream PWM logic never sees a half-updated set.
- Generalises the single-shot parallel buffer: addressed loading, overlapping updates, error reporting and an optional partial commit.

---
 rtl/modulation_buffer_dual.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/modulation_buffer_dual.sv
// Double-buffered duty/phase holding register: serial shadow load inside a START/DONE window, atomic commit on DONE.
// Optional MOD_BUFFER_PARTIAL_COMMIT_EN: commit only the entries written in the current window.
module modulation_buffer_dual #(
    parameter int unsigned  WIDTH  = 13,
    parameter int unsigned  DEPTH  = 249,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic                   WR,
    input  logic [ADDR_W-1:0]      ADDR,
    input  logic [WIDTH-1:0]       DUTY_IN,
    input  logic [WIDTH-1:0]       PHASE_IN,
    input  logic                   DONE,
    output logic [WIDTH*DEPTH-1:0] DUTY_OUT,
    output logic [WIDTH*DEPTH-1:0] PHASE_OUT,
    output logic                   BUSY,
    output logic                   UPDATE,
    output logic [ADDR_W:0]        COUNT,
    output logic                   ERR
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic do_open;
    logic do_write;
    logic do_commit;
    logic set_err;
    logic addr_ok;

    logic [WIDTH-1:0] shadow_duty  [DEPTH];
    logic [WIDTH-1:0] shadow_phase [DEPTH];
    logic [WIDTH-1:0] duty_fwd     [DEPTH];
    logic [WIDTH-1:0] phase_fwd    [DEPTH];

`ifdef MOD_BUFFER_PARTIAL_COMMIT_EN
    logic [DEPTH-1:0] mask;
    logic [DEPTH-1:0] mask_fwd;
`endif

    assign addr_ok = (CNT_W'(ADDR) < CNT_W'(DEPTH));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // DONE outranks START in LOAD; a restart discards a coincident write.
    always_comb begin
        state_nxt = state;
        do_open   = 1'b0;
        do_write  = 1'b0;
        do_commit = 1'b0;
        set_err   = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    state_nxt = LOAD;
                    do_open   = 1'b1;
                end else if (WR) begin
                    set_err = 1'b1;
                end
            end
            LOAD: begin
                if (DONE) begin
                    state_nxt = IDLE;
                    do_commit = 1'b1;
                end else if (START) begin
                    do_open = 1'b1;
                end
                if (WR && !(START && !DONE)) begin
                    if (addr_ok) do_write = 1'b1;
                    else         set_err  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow contents with the current-cycle write merged in, so a write alongside DONE lands in the commit.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            duty_fwd[i]  = shadow_duty[i];
            phase_fwd[i] = shadow_phase[i];
            if (do_write && (CNT_W'(ADDR) == CNT_W'(i))) begin
                duty_fwd[i]  = DUTY_IN;
                phase_fwd[i] = PHASE_IN;
            end
        end
    end

`ifdef MOD_BUFFER_PARTIAL_COMMIT_EN
    always_comb begin
        mask_fwd = mask;
        if (do_write) mask_fwd[ADDR] = 1'b1;
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            BUSY      <= 1'b0;
            UPDATE    <= 1'b0;
            COUNT     <= '0;
            ERR       <= 1'b0;
            DUTY_OUT  <= '0;
            PHASE_OUT <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                shadow_duty[i]  <= '0;
                shadow_phase[i] <= '0;
            end
`ifdef MOD_BUFFER_PARTIAL_COMMIT_EN
            mask <= '0;
`endif
        end else begin
            BUSY   <= (state_nxt == LOAD);
            UPDATE <= do_commit;

            if (do_open)                       COUNT <= '0;
            else if (do_write && COUNT != '1)  COUNT <= COUNT + CNT_W'(1);

            if (do_open)      ERR <= 1'b0;
            else if (set_err) ERR <= 1'b1;

`ifdef MOD_BUFFER_PARTIAL_COMMIT_EN
            if (do_open) begin
                mask <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    shadow_duty[i]  <= '0;
                    shadow_phase[i] <= '0;
                end
            end else begin
                mask <= mask_fwd;
                for (int i = 0; i < DEPTH; i++) begin
                    shadow_duty[i]  <= duty_fwd[i];
                    shadow_phase[i] <= phase_fwd[i];
                end
            end
            if (do_commit) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mask_fwd[i]) begin
                        DUTY_OUT[i*WIDTH +: WIDTH]  <= duty_fwd[i];
                        PHASE_OUT[i*WIDTH +: WIDTH] <= phase_fwd[i];
                    end
                end
            end
`else
            for (int i = 0; i < DEPTH; i++) begin
                shadow_duty[i]  <= duty_fwd[i];
                shadow_phase[i] <= phase_fwd[i];
            end
            if (do_commit) begin
                for (int i = 0; i < DEPTH; i++) begin
                    DUTY_OUT[i*WIDTH +: WIDTH]  <= duty_fwd[i];
                    PHASE_OUT[i*WIDTH +: WIDTH] <= phase_fwd[i];
                end
            end
`endif
        end
    end

endmodule
